spike_rate_decoder: RTL and testbench

//   Receive-side counterpart of the neuron spike output: converts a single-bit spike train

---
 rtl/spike_rate_decoder_if.sv | 28 ++
 rtl/spike_rate_decoder.sv | 133 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_if.sv
// Host-facing signal bundle of the spike rate decoder: control, spike input,
// rate handshake and ISI result.
interface spike_rate_decoder_if #(
  parameter int WIN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int ISI_WIDTH   = 8
);
  logic                   enable;
  logic                   spike;
  logic [WIN_WIDTH-1:0]   window_len;
  logic [COUNT_WIDTH-1:0] rate;
  logic                   rate_valid;
  logic                   rate_ready;
  logic [ISI_WIDTH-1:0]   isi;
  logic                   isi_valid;
  logic                   overrun;
  logic                   overrun_clr;

  modport master (
    output enable, spike, window_len, rate_ready, overrun_clr,
    input  rate, rate_valid, isi, isi_valid, overrun
  );

  modport slave (
    input  enable, spike, window_len, rate_ready, overrun_clr,
    output rate, rate_valid, isi, isi_valid, overrun
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Converts a spike train into a windowed firing rate (valid/ready) and an
// inter-spike interval (one-cycle valid pulse).
module spike_rate_decoder #(
  parameter int WIN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int ISI_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  spike_rate_decoder_if.slave bus
);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e                 state_q, state_d;
  logic [WIN_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic [COUNT_WIDTH-1:0] spk_cnt_q, spk_cnt_d, spk_inc;
  logic [COUNT_WIDTH-1:0] rate_q, rate_d;
  logic [ISI_WIDTH-1:0]   isi_cnt_q, isi_cnt_d, isi_inc;
  logic [ISI_WIDTH-1:0]   isi_q, isi_d;
  logic                   rate_valid_q, rate_valid_d;
  logic                   isi_valid_q, isi_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   have_prev_q, have_prev_d;
  logic                   new_res;

  always_comb begin
    spk_inc = (bus.spike && spk_cnt_q != '1) ? spk_cnt_q + COUNT_WIDTH'(1) : spk_cnt_q;
    isi_inc = (isi_cnt_q != '1) ? isi_cnt_q + ISI_WIDTH'(1) : isi_cnt_q;

    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    isi_cnt_d    = isi_cnt_q;
    have_prev_d  = have_prev_q;
    rate_d       = rate_q;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;
    new_res      = 1'b0;

    case (state_q)
      IDLE: begin
        win_cnt_d   = '0;
        spk_cnt_d   = '0;
        isi_cnt_d   = '0;
        have_prev_d = 1'b0;
        if (bus.enable) begin
          state_d   = COUNT;
          win_cnt_d = bus.window_len;
        end
      end
      COUNT: begin
        if (!bus.enable) begin
          state_d     = IDLE;
          win_cnt_d   = '0;
          spk_cnt_d   = '0;
          isi_cnt_d   = '0;
          have_prev_d = 1'b0;
        end else begin
          // Last window cycle folds its own spike into the result; next window starts immediately.
          if (win_cnt_q == '0) begin
            new_res   = 1'b1;
            rate_d    = spk_inc;
            spk_cnt_d = '0;
            win_cnt_d = bus.window_len;
          end else begin
            win_cnt_d = win_cnt_q - WIN_WIDTH'(1);
            spk_cnt_d = spk_inc;
          end

          if (bus.spike) begin
            isi_cnt_d   = '0;
            have_prev_d = 1'b1;
            if (have_prev_q) begin
              isi_d       = isi_inc;
              isi_valid_d = 1'b1;
            end
          end else begin
            isi_cnt_d = isi_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (new_res)
      rate_valid_d = 1'b1;
    else if (rate_valid_q && bus.rate_ready)
      rate_valid_d = 1'b0;
    else
      rate_valid_d = rate_valid_q;

    if (new_res && rate_valid_q && !bus.rate_ready)
      overrun_d = 1'b1;
    else if (bus.overrun_clr)
      overrun_d = 1'b0;
    else
      overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      isi_cnt_q    <= '0;
      have_prev_q  <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      have_prev_q  <= have_prev_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios followed by random traffic,
// compared against a time-stamp based reference model.
module tb_spike_rate_decoder;

  localparam int MAXV = 255;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  spike_rate_decoder_if #(.WIN_WIDTH(8), .COUNT_WIDTH(8), .ISI_WIDTH(8)) bus ();

  spike_rate_decoder #(.WIN_WIDTH(8), .COUNT_WIDTH(8), .ISI_WIDTH(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: absolute COUNT-cycle time stamps for window starts and spikes.
  bit m_act;
  int m_t, m_ws, m_wl, m_spk, m_last;
  int m_rate, m_isi;
  bit m_rv, m_iv, m_ovr;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_ws = 0; m_wl = 0; m_spk = 0; m_last = -1;
    m_rate = 0; m_isi = 0; m_rv = 0; m_iv = 0; m_ovr = 0;
  endtask

  task automatic model_step(input logic en, input logic sp, input int wl,
                            input logic rdy, input logic clr);
    bit res_new;
    int res;
    bit set;
    res_new = 0;
    res     = 0;
    m_iv    = 0;
    if (!m_act) begin
      if (en) begin
        m_act = 1; m_t = 0; m_ws = 0; m_wl = wl; m_spk = 0; m_last = -1;
      end
    end else if (!en) begin
      m_act = 0;
    end else begin
      if (sp) begin
        m_spk++;
        if (m_last >= 0) begin
          m_isi = sat(m_t - m_last);
          m_iv  = 1;
        end
        m_last = m_t;
      end
      if (m_t - m_ws == m_wl) begin
        res_new = 1;
        res     = sat(m_spk);
        m_spk   = 0;
        m_ws    = m_t + 1;
        m_wl    = wl;
      end
      m_t++;
    end
    set = res_new && m_rv && !rdy;
    if (res_new) begin
      m_rate = res;
      m_rv   = 1;
    end else if (m_rv && rdy) begin
      m_rv = 0;
    end
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("rate", 32'(bus.rate), m_rate);
    chk("rate_valid", 32'(bus.rate_valid), 32'(m_rv));
    chk("isi", 32'(bus.isi), m_isi);
    chk("isi_valid", 32'(bus.isi_valid), 32'(m_iv));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic cycle(input logic en, input logic sp, input int wl,
                       input logic rdy, input logic clr);
    bus.enable      = en;
    bus.spike       = sp;
    bus.window_len  = 8'(wl);
    bus.rate_ready  = rdy;
    bus.overrun_clr = clr;
    @(posedge clk);
    model_step(en, sp, wl, rdy, clr);
    #1;
    chk_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rate"}, 32'(bus.rate), 0);
    chk({tag, "_rv"}, 32'(bus.rate_valid), 0);
    chk({tag, "_isi"}, 32'(bus.isi), 0);
    chk({tag, "_iv"}, 32'(bus.isi_valid), 0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 0);
  endtask

  initial begin
    int rv_cnt;
    int n;
    checks = 0;
    errors = 0;
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.spike       = 1'b0;
    bus.window_len  = '0;
    bus.rate_ready  = 1'b0;
    bus.overrun_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("por");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Window of 10, spikes on window cycles 0,3,6,9: rate 4 every 10 cycles.
    cycle(1, 0, 9, 1, 0);
    rv_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1, ((k % 10) % 3) == 0, 9, 1, 0);
      if (bus.rate_valid === 1'b1) begin
        rv_cnt++;
        chk("rate4", 32'(bus.rate), 4);
      end
    end
    chk("rate4_pulses", rv_cnt, 3);

    // Asynchronous reset while a result is pending.
    cycle(1, 0, 9, 0, 0);
    chk("pre_rst_rv", 32'(bus.rate_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle(0, 1, 9, 0, 0);
    chk("post_rst_rv", 32'(bus.rate_valid), 0);

    // Spike held high across a 256-cycle window saturates the count.
    cycle(1, 1, 255, 1, 0);
    for (int k = 0; k < 256; k++) cycle(1, 1, 255, 1, 0);
    chk("sat_rate", 32'(bus.rate), 255);
    chk("sat_rv", 32'(bus.rate_valid), 1);
    chk("sat_ovr", 32'(bus.overrun), 0);

    // ISI: spikes at COUNT cycles 5 and 12, then a 300-cycle gap.
    cycle(0, 0, 255, 1, 0);
    cycle(1, 0, 255, 1, 0);
    for (int k = 0; k <= 312; k++) begin
      cycle(1, (k == 5) || (k == 12) || (k == 312), 255, 1, 0);
      if (k == 5) chk("isi_first", 32'(bus.isi_valid), 0);
      if (k == 12) begin
        chk("isi7_v", 32'(bus.isi_valid), 1);
        chk("isi7", 32'(bus.isi), 7);
      end
      if (k == 13) chk("isi_pulse", 32'(bus.isi_valid), 0);
      if (k == 312) begin
        chk("isi_sat_v", 32'(bus.isi_valid), 1);
        chk("isi_sat", 32'(bus.isi), 255);
      end
    end

    // Two unread windows overwrite and set overrun; clear pulse drops it.
    cycle(0, 0, 4, 1, 0);
    cycle(1, 0, 4, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, ($urandom_range(0, 1) == 1), 4, 0, 0);
    chk("ovr_set", 32'(bus.overrun), 1);
    chk("ovr_rv", 32'(bus.rate_valid), 1);
    cycle(1, 0, 4, 0, 1);
    chk("ovr_clr", 32'(bus.overrun), 0);
    cycle(0, 0, 4, 1, 0);

    // Enable dropped mid-window, then a full window before the next result.
    cycle(0, 0, 7, 1, 0);
    cycle(1, 0, 7, 1, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 7, 1, 0);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 7, 1, 0);
      chk("drop_rv", 32'(bus.rate_valid), 0);
    end
    cycle(1, 0, 7, 1, 0);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      cycle(1, 1, 7, 1, 0);
      if (bus.rate_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("reenable_latency", n, 8);
    chk("reenable_rate", 32'(bus.rate), 8);

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      cycle($urandom_range(0, 19) != 0,
            $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 12)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
